// File: rtl/ldpc_layer_scheduler_pkg.sv
// Shared constants, state encoding and base-matrix table accessors for the
// layered min-sum decoder scheduler.
package ldpc_layer_scheduler_pkg;

    localparam int NUM_COLS    = 16;
    localparam int NUM_LAYERS  = 8;
    localparam int WIDTH_Z     = 6;
    localparam int WIDTH_LAYER = 3;
    localparam int WIDTH_COL   = 4;
    localparam int WIDTH_ITER  = 5;

    localparam int ROT_BITS = WIDTH_Z * NUM_LAYERS * NUM_COLS;
    localparam int FIC_BITS = 2 * NUM_LAYERS * NUM_COLS;

    // An all-ones rotation marks an empty circulant.
    localparam logic [WIDTH_Z-1:0]     ROT_EMPTY    = {WIDTH_Z{1'b1}};
    localparam logic [NUM_COLS-1:0]    COL_ONE      = {{(NUM_COLS-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_ITER-1:0]  ITER_ONE     = 5'd1;
    localparam logic [WIDTH_LAYER:0]   LAYERS_MAX_V = 4'd8;

    // first_in_col encodings
    localparam logic [1:0] FIC_FIRST  = 2'b01;
    localparam logic [1:0] FIC_LATER  = 2'b00;
    localparam logic [1:0] FIC_UNUSED = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    function automatic logic [WIDTH_Z-1:0] rot_at(
        input logic [ROT_BITS-1:0]    tbl,
        input logic [WIDTH_LAYER-1:0] l,
        input logic [WIDTH_COL-1:0]   c
    );
        return tbl[(int'(l) * NUM_COLS + int'(c)) * WIDTH_Z +: WIDTH_Z];
    endfunction

    function automatic logic [1:0] fic_at(
        input logic [FIC_BITS-1:0]    tbl,
        input logic [WIDTH_LAYER-1:0] l,
        input logic [WIDTH_COL-1:0]   c
    );
        return tbl[(int'(l) * NUM_COLS + int'(c)) * 2 +: 2];
    endfunction

    // One bit per column: set where the layer holds a non-empty circulant.
    function automatic logic [NUM_COLS-1:0] layer_mask(
        input logic [ROT_BITS-1:0]    tbl,
        input logic [WIDTH_LAYER-1:0] l
    );
        logic [NUM_COLS-1:0] m;
        m = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            m[c] = (tbl[(int'(l) * NUM_COLS + c) * WIDTH_Z +: WIDTH_Z] != ROT_EMPTY);
        end
        return m;
    endfunction

    function automatic logic [WIDTH_LAYER:0] clamp_layers(input logic [WIDTH_LAYER:0] n);
        return (n > LAYERS_MAX_V) ? LAYERS_MAX_V : n;
    endfunction

endpackage

// File: rtl/ldpc_col_picker.sv
// Lowest-set-bit priority encoder over the per-layer column mask.
module ldpc_col_picker
    import ldpc_layer_scheduler_pkg::*;
(
    input  logic [NUM_COLS-1:0]  mask,
    output logic [WIDTH_COL-1:0] idx,
    output logic [NUM_COLS-1:0]  onehot,
    output logic                 any,
    output logic                 single
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            idx = mask[i] ? WIDTH_COL'(i) : idx;
        end
    end

    assign onehot = mask & (~mask + COL_ONE);
    assign any    = |mask;
    assign single = any && ((mask & (mask - COL_ONE)) == '0);

endmodule

// File: rtl/ldpc_layer_scheduler.sv
// Layer/column sequencer for the layered min-sum LDPC decoder. All outputs
// are registered; the next command is computed from the next-cycle mask so
// back-to-back handshakes proceed without bubbles.
module ldpc_layer_scheduler
    import ldpc_layer_scheduler_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [WIDTH_ITER-1:0]  max_iter,
    input  logic [WIDTH_LAYER:0]   num_layers,
    input  logic [ROT_BITS-1:0]    idx_rot,
    input  logic [FIC_BITS-1:0]    first_in_col,
    output logic                   col_valid,
    input  logic                   col_ready,
    output logic [WIDTH_LAYER-1:0] col_layer,
    output logic [WIDTH_COL-1:0]   col_idx,
    output logic [WIDTH_Z-1:0]     col_rot,
    output logic                   col_first,
    output logic                   col_last,
    input  logic                   layer_done,
    input  logic                   parity_ok,
    output logic [WIDTH_ITER-1:0]  iter_cnt,
    output logic                   busy,
    output logic                   done,
    output logic                   converged
);

    state_e                 state_q, state_d;
    logic [WIDTH_LAYER-1:0] layer_q, layer_d;
    logic [NUM_COLS-1:0]    mask_q, mask_d;
    logic [WIDTH_ITER-1:0]  iter_q, iter_d;
    logic [WIDTH_ITER-1:0]  max_q, max_d;
    logic [WIDTH_LAYER:0]   nl_q, nl_d;
    logic [ROT_BITS-1:0]    rot_tbl_q, rot_tbl_d;
    logic [FIC_BITS-1:0]    fic_tbl_q, fic_tbl_d;
    logic                   conv_q, conv_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   col_valid_q, col_valid_d;
    logic [WIDTH_COL-1:0]   col_idx_q, col_idx_d;
    logic [NUM_COLS-1:0]    col_oh_q, col_oh_d;
    logic [WIDTH_Z-1:0]     col_rot_q, col_rot_d;
    logic                   col_first_q, col_first_d;
    logic                   col_last_q, col_last_d;

    logic [WIDTH_COL-1:0]   pick_idx_s;
    logic [NUM_COLS-1:0]    pick_oh_s;
    logic                   pick_any_s;
    logic                   pick_single_s;
    logic                   last_layer_s;
    logic [WIDTH_ITER-1:0]  iter_inc_s;
    logic [WIDTH_LAYER:0]   nl_clamp_s;

    // The picker looks at the mask as it will be next cycle.
    ldpc_col_picker u_picker (
        .mask   (mask_d),
        .idx    (pick_idx_s),
        .onehot (pick_oh_s),
        .any    (pick_any_s),
        .single (pick_single_s)
    );

    assign last_layer_s = (({1'b0, layer_q} + 4'd1) >= nl_q);
    assign iter_inc_s   = (iter_q < max_q) ? (iter_q + ITER_ONE) : iter_q;
    assign nl_clamp_s   = clamp_layers(num_layers);

    // Next-state, layer/mask sequencing, iteration and result bookkeeping.
    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        mask_d    = mask_q;
        iter_d    = iter_q;
        max_d     = max_q;
        nl_d      = nl_q;
        rot_tbl_d = rot_tbl_q;
        fic_tbl_d = fic_tbl_q;
        conv_d    = conv_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                rot_tbl_d = idx_rot;
                fic_tbl_d = first_in_col;
                nl_d      = nl_clamp_s;
                max_d     = (max_iter == 5'd0) ? ITER_ONE : max_iter;
                iter_d    = '0;
                layer_d   = '0;
                conv_d    = 1'b0;
                if (nl_clamp_s == 4'd0) begin
                    mask_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    mask_d  = layer_mask(idx_rot, 3'd0);
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (mask_q == '0) begin
                    // Empty layer: move on without waiting for writeback.
                    if (last_layer_s) begin
                        state_d = ST_CHECK;
                    end else begin
                        layer_d = layer_q + 3'd1;
                        mask_d  = layer_mask(rot_tbl_q, layer_q + 3'd1);
                        state_d = ST_SCAN;
                    end
                end else if (col_valid_q && col_ready) begin
                    mask_d = mask_q & ~col_oh_q;
                    if (col_last_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DRAIN: begin
                if (!layer_done) begin
                    state_d = ST_DRAIN;
                end else if (last_layer_s) begin
                    state_d = ST_CHECK;
                end else begin
                    layer_d = layer_q + 3'd1;
                    mask_d  = layer_mask(rot_tbl_q, layer_q + 3'd1);
                    state_d = ST_SCAN;
                end
            end
            ST_CHECK: begin
                iter_d = iter_inc_s;
                if (parity_ok) begin
                    conv_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (iter_inc_s == max_q) begin
                    state_d = ST_DONE;
                end else begin
                    layer_d = '0;
                    mask_d  = layer_mask(rot_tbl_q, 3'd0);
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                mask_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
        // Abort overrides everything decided above.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            mask_d  = '0;
            conv_d  = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // Registered command/status outputs; command fields hold while no column is offered.
    always_comb begin
        col_valid_d = (state_d == ST_SCAN) && pick_any_s;
        done_d      = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        if (col_valid_d) begin
            col_idx_d   = pick_idx_s;
            col_oh_d    = pick_oh_s;
            col_rot_d   = rot_at(rot_tbl_d, layer_d, pick_idx_s);
            col_first_d = (fic_at(fic_tbl_d, layer_d, pick_idx_s) == FIC_FIRST) && (iter_d == 5'd0);
            col_last_d  = pick_single_s;
        end else begin
            col_idx_d   = col_idx_q;
            col_oh_d    = col_oh_q;
            col_rot_d   = col_rot_q;
            col_first_d = col_first_q;
            col_last_d  = col_last_q;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            layer_q     <= '0;
            mask_q      <= '0;
            iter_q      <= '0;
            max_q       <= '0;
            nl_q        <= '0;
            rot_tbl_q   <= '0;
            fic_tbl_q   <= '0;
            conv_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            col_valid_q <= 1'b0;
            col_idx_q   <= '0;
            col_oh_q    <= '0;
            col_rot_q   <= '0;
            col_first_q <= 1'b0;
            col_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            mask_q      <= mask_d;
            iter_q      <= iter_d;
            max_q       <= max_d;
            nl_q        <= nl_d;
            rot_tbl_q   <= rot_tbl_d;
            fic_tbl_q   <= fic_tbl_d;
            conv_q      <= conv_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            col_valid_q <= col_valid_d;
            col_idx_q   <= col_idx_d;
            col_oh_q    <= col_oh_d;
            col_rot_q   <= col_rot_d;
            col_first_q <= col_first_d;
            col_last_q  <= col_last_d;
        end
    end

    assign col_valid = col_valid_q;
    assign col_layer = layer_q;
    assign col_idx   = col_idx_q;
    assign col_rot   = col_rot_q;
    assign col_first = col_first_q;
    assign col_last  = col_last_q;
    assign iter_cnt  = iter_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign converged = conv_q;

endmodule

// File: tb/tb_ldpc_layer_scheduler.sv
// Directed bench for ldpc_layer_scheduler using a hand-built 8x16 base matrix.
module tb_ldpc_layer_scheduler;
    import ldpc_layer_scheduler_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start, abort, parity_ok;
    logic                   col_ready  = 1'b1;
    logic                   layer_done = 1'b0;
    logic [WIDTH_ITER-1:0]  max_iter;
    logic [WIDTH_LAYER:0]   num_layers;
    logic [ROT_BITS-1:0]    idx_rot;
    logic [FIC_BITS-1:0]    first_in_col;
    logic                   col_valid, col_first, col_last, busy, done, converged;
    logic [WIDTH_LAYER-1:0] col_layer;
    logic [WIDTH_COL-1:0]   col_idx;
    logic [WIDTH_Z-1:0]     col_rot;
    logic [WIDTH_ITER-1:0]  iter_cnt;

    ldpc_layer_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .max_iter(max_iter), .num_layers(num_layers), .idx_rot(idx_rot),
        .first_in_col(first_in_col), .col_valid(col_valid), .col_ready(col_ready),
        .col_layer(col_layer), .col_idx(col_idx), .col_rot(col_rot),
        .col_first(col_first), .col_last(col_last), .layer_done(layer_done),
        .parity_ok(parity_ok), .iter_cnt(iter_cnt), .busy(busy), .done(done),
        .converged(converged)
    );

    always #5 clk = ~clk;

    int rot_tab [NUM_LAYERS][NUM_COLS];
    int n_tests = 0;
    int n_fail  = 0;
    int q_idx[$], q_rot[$], q_first[$], q_last[$], q_layer[$];
    int rdy_mode = 0, phase = 0, auto_ld = 1, ld_cnt = 0, stab_err = 0, stalls = 0;
    int prev_idx = 0, prev_rot = 0;
    logic prev_stall = 1'b0;
    int got, cyc, seen;
    int exp_idx [7] = '{0, 2, 4, 6, 8, 11, 12};
    int exp_rot [7] = '{35, 41, 40, 39, 28, 3, 28};
    int exp_r0  [5] = '{40, 38, 13, 5, 18};

    // Datapath stand-in: ready policy, stall stability, handshake log, layer_done reply.
    always @(negedge clk) begin
        case (rdy_mode)
            0: col_ready = 1'b1;
            1: begin
                if (col_layer == 3'd4) begin
                    col_ready = (phase == 0);
                    phase = (phase + 1) % 3;
                end else begin
                    col_ready = 1'b1;
                end
            end
            default: col_ready = 1'b0;
        endcase
        if (prev_stall && rst_n) begin
            stalls++;
            if (!col_valid || int'(col_idx) != prev_idx || int'(col_rot) != prev_rot) stab_err++;
        end
        prev_stall = col_valid && !col_ready && !abort;
        prev_idx   = int'(col_idx);
        prev_rot   = int'(col_rot);
        layer_done = 1'b0;
        if (ld_cnt > 0) begin
            ld_cnt--;
            if (ld_cnt == 0) layer_done = 1'b1;
        end
        if (col_valid && col_ready && !abort && rst_n) begin
            q_idx.push_back(int'(col_idx));
            q_rot.push_back(int'(col_rot));
            q_first.push_back(int'(col_first));
            q_last.push_back(int'(col_last));
            q_layer.push_back(int'(col_layer));
            if (col_last && auto_ld != 0) ld_cnt = 2;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int l, input int c, input int r);
        rot_tab[l][c] = r;
    endtask

    task automatic clear_log();
        q_idx.delete(); q_rot.delete(); q_first.delete(); q_last.delete(); q_layer.delete();
    endtask

    // Start a decode and wait (bounded) for the done pulse; optionally pulse start mid-run.
    task automatic run(input int mi, input logic po, input int start_mid);
        int pulsed;
        repeat (2) step();
        clear_log();
        parity_ok = po;
        max_iter  = WIDTH_ITER'(mi);
        start = 1'b1;
        step();
        start  = 1'b0;
        got    = 0;
        cyc    = 0;
        pulsed = 0;
        while (got == 0 && cyc < 4000) begin
            if (start_mid != 0 && pulsed == 0 && q_idx.size() >= 20) begin
                start  = 1'b1;
                pulsed = 1;
            end else begin
                start = 1'b0;
            end
            step();
            cyc++;
            if (done) got = 1;
        end
        start = 1'b0;
        check("done_seen", got, 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; parity_ok = 1'b0;
        max_iter = '0; num_layers = 4'd8;
        for (int l = 0; l < NUM_LAYERS; l++)
            for (int c = 0; c < NUM_COLS; c++) rot_tab[l][c] = 63;
        put(0,0,40); put(0,2,38); put(0,4,13); put(0,6,5);  put(0,8,18);
        put(1,0,10); put(1,1,7);  put(1,3,22); put(1,5,9);  put(1,7,30); put(1,9,11); put(1,10,2);
        put(2,1,3);  put(2,2,17); put(2,11,8); put(2,12,21); put(2,13,1); put(2,14,33);
        put(3,0,4);  put(3,3,15); put(3,5,27); put(3,9,6);  put(3,13,19); put(3,14,12); put(3,15,0);
        put(4,0,35); put(4,2,41); put(4,4,40); put(4,6,39); put(4,8,28); put(4,11,3); put(4,12,28);
        put(5,1,14); put(5,3,20); put(5,5,25); put(5,7,16); put(5,10,29); put(5,13,31); put(5,15,23);
        put(6,0,26); put(6,2,36); put(6,9,37); put(6,10,24); put(6,11,32); put(6,14,34);
        put(7,1,1);  put(7,3,7);  put(7,4,2);  put(7,6,9);  put(7,8,12); put(7,12,5); put(7,15,24);
        for (int l = 0; l < NUM_LAYERS; l++)
            for (int c = 0; c < NUM_COLS; c++) idx_rot[(l*NUM_COLS+c)*WIDTH_Z +: WIDTH_Z] = WIDTH_Z'(rot_tab[l][c]);
        for (int c = 0; c < NUM_COLS; c++) begin
            seen = 0;
            for (int l = 0; l < NUM_LAYERS; l++) begin
                if (rot_tab[l][c] == 63) first_in_col[(l*NUM_COLS+c)*2 +: 2] = 2'b11;
                else begin
                    first_in_col[(l*NUM_COLS+c)*2 +: 2] = (seen != 0) ? 2'b00 : 2'b01;
                    seen = 1;
                end
            end
        end

        repeat (3) step();
        check("rst_flags", {col_valid, busy, done, converged, col_first, col_last}, 0);
        check("rst_iter", iter_cnt, 0);
        check("rst_col", {col_layer, col_idx, col_rot}, 0);
        rst_n = 1'b1;
        step();

        // 1: single iteration, layer 0 and layer 7 contents
        run(1, 1'b0, 0);
        check("t1_hs_count", q_idx.size(), 52);
        for (int i = 0; i < 5; i++) begin
            check("t1_l0_idx", q_idx[i], 2*i);
            check("t1_l0_rot", q_rot[i], exp_r0[i]);
            check("t1_l0_first", q_first[i], 1);
        end
        check("t1_l0_last_c6", q_last[3], 0);
        check("t1_l0_last_c8", q_last[4], 1);
        check("t1_l7_end", {q_layer[51], q_idx[51], q_rot[51], q_last[51]}, {32'd7, 32'd15, 32'd24, 32'd1});
        check("t1_iter", iter_cnt, 1);
        check("t1_conv", converged, 0);

        // 2: second iteration clears col_first
        run(2, 1'b0, 0);
        check("t2_hs_count", q_idx.size(), 104);
        check("t2_i1_l1c0_first", q_first[5], 0);
        check("t2_i1_l1c7", {q_idx[9], q_rot[9], q_first[9]}, {32'd7, 32'd30, 32'd1});
        check("t2_i2_l0c0_first", {q_idx[52], q_first[52]}, {32'd0, 32'd0});
        check("t2_i2_l1c0", {q_layer[57], q_idx[57], q_first[57]}, {32'd1, 32'd0, 32'd0});
        check("t2_i2_l1c7", {q_idx[61], q_rot[61], q_first[61]}, {32'd7, 32'd30, 32'd0});
        check("t2_iter", iter_cnt, 2);

        // 3: convergence at the first check; start while busy is ignored
        run(10, 1'b1, 1);
        check("t3_hs_count", q_idx.size(), 52);
        check("t3_iter", iter_cnt, 1);
        check("t3_conv", converged, 1);

        // num_layers = 0: straight to done, never converged
        num_layers = 4'd0;
        run(5, 1'b1, 0);
        check("nl0_hs_count", q_idx.size(), 0);
        check("nl0_iter", iter_cnt, 0);
        check("nl0_conv", converged, 0);

        // 4: iteration limit, max_iter=0 as 1, num_layers clamped
        num_layers = 4'd8;
        run(3, 1'b0, 0);
        check("t4_hs_count", q_idx.size(), 156);
        check("t4_iter", iter_cnt, 3);
        check("t4_conv", converged, 0);
        num_layers = 4'd15;
        run(0, 1'b0, 0);
        check("t4_mi0_hs_count", q_idx.size(), 52);
        check("t4_mi0_iter", iter_cnt, 1);
        num_layers = 4'd8;

        // 5: back-pressure during layer 4
        rdy_mode = 1; phase = 0; stalls = 0; stab_err = 0;
        run(1, 1'b0, 0);
        rdy_mode = 0;
        check("t5_hs_count", q_idx.size(), 52);
        check("t5_stalls_seen", stalls > 0, 1);
        check("t5_stable", stab_err, 0);
        for (int i = 0; i < 7; i++) begin
            check("t5_l4_idx", q_idx[25+i], exp_idx[i]);
            check("t5_l4_rot", q_rot[25+i], exp_rot[i]);
        end

        // 6a: abort during layer 3
        repeat (2) step();
        clear_log();
        parity_ok = 1'b0; max_iter = 5'd5;
        start = 1'b1; step(); start = 1'b0;
        got = 0; cyc = 0;
        while (got == 0 && cyc < 2000) begin
            step(); cyc++;
            if (col_valid && col_layer == 3'd3) got = 1;
        end
        check("t6_reach_l3", got, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t6_abort_state", {busy, col_valid, done, converged}, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) seen++;
        end
        check("t6_abort_no_done", seen, 0);

        // 6b: asynchronous reset while waiting for layer_done
        auto_ld = 0;
        repeat (2) step();
        clear_log();
        max_iter = 5'd1;
        start = 1'b1; step(); start = 1'b0;
        got = 0; cyc = 0;
        while (got == 0 && cyc < 200) begin
            step(); cyc++;
            if (q_idx.size() == 5 && busy && !col_valid) got = 1;
        end
        check("t6_reach_drain", got, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_flags", {busy, col_valid, done, converged, col_first, col_last}, 0);
        check("t6_rst_col", {col_layer, col_idx, col_rot}, 0);
        check("t6_rst_iter", iter_cnt, 0);
        step();
        rst_n = 1'b1; auto_ld = 1; ld_cnt = 0;
        step();
        run(1, 1'b0, 0);
        check("t6_rerun_hs_count", q_idx.size(), 52);
        check("t6_rerun_first", {q_layer[0], q_idx[0], q_rot[0]}, {32'd0, 32'd0, 32'd40});
        check("t6_rerun_iter", iter_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
